alu_mem_unit: RTL and testbench
===============================

# alu_mem_unit

Execution and storage slice of the 8-bit single-cycle processor datapath. It bundles three independent functions behind one clock and reset:
- a 256-entry instruction ROM that splits each word into its fields;
- an 8-bit two-function ALU;
- a 256×8 data RAM with synchronous write and asynchronous read.

The program counter and decoder upstream, and the write-back mux downstream, connect to these ports directly.

## Interface
Parameters:
- None. Data width is fixed at 8 bits and address width at 8 bits.

Ports:
- sysclk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr_addr  in  8  instruction ROM address (from PC)
- opcode  out  3  instruction field [7:5]
- rs  out  1  instruction field [4]
- rt  out  1  instruction field [3]
- aux  out  3  instruction field [2:0] (immediate)
- alu_a  in  8  ALU operand A
- alu_b  in  8  ALU operand B
- alu_imm  in  3  shift amount
- alu_op  in  1  0 = add, 1 = shift-left
- alu_result  out  8  ALU result
- mem_addr  in  8  data RAM address
- mem_wdata  in  8  data RAM write data
- mem_write  in  1  data RAM write enable
- mem_rdata  out  8  data RAM read data

## Operation
Instruction ROM:
- Combinational, read-only.
- Contents by address: 0:0x0B, 1:0x52, 2:0x9D, 3:0x64, 4:0x27, 5:0xE1, 6:0x18, 7:0xB6. All other addresses (8–255) hold 0x00.
- Outputs are {opcode, rs, rt, aux} = word[7:5], [4], [3], [2:0] of the word at instr_addr.
- Unaffected by rst_n.

ALU:
- Purely combinational.
- alu_op=0: alu_result = (alu_a + alu_b) mod 256. Carry is discarded; no flags.
- alu_op=1: alu_result = (alu_a << alu_imm) mod 256, logical shift with zero fill. alu_imm=0 passes alu_a unchanged. alu_b is ignored.
- Unaffected by rst_n.

Data RAM:
- 256×8.
- mem_rdata = mem[mem_addr] asynchronously; it follows mem_addr changes within the same cycle.
- Write: on a rising sysclk edge with rst_n=1 and mem_write=1, mem[mem_addr] ← mem_wdata.
- rst_n low: all 256 entries clear to 0x00 immediately, and stay cleared while rst_n is low. mem_rdata reads 0x00 during reset.

## Timing
- ROM and ALU have zero-cycle latency: outputs are valid within the same cycle as their inputs.
- RAM write takes effect at the rising edge and is visible on mem_rdata just after that edge.
- Read and write to the same address in the same cycle: before the edge mem_rdata shows the old value; after the edge it shows the new value. No bypass.
- Reset dominates: if rst_n is low at an edge, no write occurs even with mem_write=1.
- Reset asserted mid-cycle clears memory without waiting for a clock edge.
- rst_n deassertion is synchronized externally. The first write is allowed on the first edge after rst_n goes high.
- mem_write=0 at an edge leaves memory unchanged.
- No handshakes and no FSM.

## Test plan
- ROM decode:
  - instr_addr=2 → opcode=3'b100, rs=1, rt=1, aux=3'b101.
  - instr_addr=5 (0xE1) → opcode=7, rs=0, rt=0, aux=1.
  - instr_addr=200 → all fields 0.
- ALU add with wrap: alu_op=0, a=0xF0, b=0x25 → 0x15. a=3, b=4 → 7.
- ALU shift:
  - alu_op=1, a=0x81, imm=1 → 0x02.
  - a=0x01, imm=7 → 0x80.
  - imm=0 → a unchanged.
  - Changing b has no effect on the result.
- RAM write then read:
  - Write 0xA5 to address 0x10 on one edge.
  - mem_rdata=0xA5 after that edge.
  - Address 0x11 still reads 0x00.
- RAM write-disable and same-cycle read:
  - mem_write=0, wdata=0x3C at address 0x10 → still 0xA5.
  - Then enable the write → 0xA5 before the edge, 0x3C after it.
- Async reset:
  - After the writes above, pull rst_n low mid-cycle → address 0x10 reads 0x00 with no clock edge.
  - Hold mem_write=1 with rst_n low across an edge → memory stays 0.
  - Release reset; the next write succeeds.

Source files
------------

// File: rtl/alu_mem_unit.sv
// Execution/storage slice of the 8-bit datapath: instruction ROM field split,
// two-function ALU, and 256x8 data RAM (sync write, async read, async clear).
module alu_mem_unit (
   input  logic       sysclk,
   input  logic       rst_n,
   // instruction ROM
   input  logic [7:0] instr_addr,
   output logic [2:0] opcode,
   output logic       rs,
   output logic       rt,
   output logic [2:0] aux,
   // ALU
   input  logic [7:0] alu_a,
   input  logic [7:0] alu_b,
   input  logic [2:0] alu_imm,
   input  logic       alu_op,
   output logic [7:0] alu_result,
   // data RAM
   input  logic [7:0] mem_addr,
   input  logic [7:0] mem_wdata,
   input  logic       mem_write,
   output logic [7:0] mem_rdata
);

   // ------------------------------------------------------------------
   // Instruction ROM: only the first eight words are populated.
   // ------------------------------------------------------------------
   logic [7:0] instr_word;

   always_comb begin
      instr_word = 8'h00;
      case (instr_addr)
         8'd0:    instr_word = 8'h0B;
         8'd1:    instr_word = 8'h52;
         8'd2:    instr_word = 8'h9D;
         8'd3:    instr_word = 8'h64;
         8'd4:    instr_word = 8'h27;
         8'd5:    instr_word = 8'hE1;
         8'd6:    instr_word = 8'h18;
         8'd7:    instr_word = 8'hB6;
         default: instr_word = 8'h00;
      endcase
   end

   assign opcode = instr_word[7:5];
   assign rs     = instr_word[4];
   assign rt     = instr_word[3];
   assign aux    = instr_word[2:0];

   // ------------------------------------------------------------------
   // ALU: add with carry dropped, or logical left shift by alu_imm.
   // ------------------------------------------------------------------
   logic [7:0] alu_sum;
   logic [7:0] alu_shl;

   assign alu_sum = alu_a + alu_b;
   assign alu_shl = alu_a << alu_imm;

   always_comb begin
      alu_result = alu_sum;
      if (alu_op) begin
         alu_result = alu_shl;
      end
   end

   // ------------------------------------------------------------------
   // Data RAM. The async reset clears every entry, so reads during reset
   // naturally return zero and writes are blocked while rst_n is low.
   // ------------------------------------------------------------------
   logic [7:0] mem_q [256];

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (mem_write) begin
         mem_q[mem_addr] <= mem_wdata;
      end
   end

   assign mem_rdata = mem_q[mem_addr];

endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: randomized stimulus against a
// behavioural model (ROM table, arithmetic ALU, array-backed RAM).
module tb_alu_mem_unit;

   logic       sysclk;
   logic       rst_n;
   logic [7:0] instr_addr;
   logic [2:0] opcode;
   logic       rs;
   logic       rt;
   logic [2:0] aux;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_imm;
   logic       alu_op;
   logic [7:0] alu_result;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_write;
   logic [7:0] mem_rdata;

   int checks;
   int failures;

   logic [7:0] ref_mem [256];
   logic [7:0] rom_table [8];

   alu_mem_unit dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .instr_addr (instr_addr),
      .opcode     (opcode),
      .rs         (rs),
      .rt         (rt),
      .aux        (aux),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_imm    (alu_imm),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_write  (mem_write),
      .mem_rdata  (mem_rdata)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   function automatic logic [7:0] rom_ref(input int addr);
      if (addr < 8) return rom_table[addr];
      return 8'h00;
   endfunction

   function automatic logic [7:0] alu_ref(input int a, input int b, input int imm,
                                          input logic op);
      int r;
      if (op) r = (a * (1 << imm)) % 256;
      else    r = (a + b) % 256;
      return r[7:0];
   endfunction

   // Model write at the edge, honouring reset dominance.
   task automatic model_edge();
      if (rst_n && mem_write) ref_mem[mem_addr] = mem_wdata;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
   endtask

   task automatic check_rom(input int addr, input string name);
      logic [7:0] exp;
      instr_addr = addr[7:0];
      #1;
      exp = rom_ref(addr);
      checks++;
      if ({opcode, rs, rt, aux} !== exp) begin
         failures++;
         $display("FAIL %s addr=%0d got=%h exp=%h", name, addr,
                  {opcode, rs, rt, aux}, exp);
      end
   endtask

   task automatic check_alu(input int a, input int b, input int imm, input logic op,
                            input string name);
      logic [7:0] exp;
      alu_a = a[7:0]; alu_b = b[7:0]; alu_imm = imm[2:0]; alu_op = op;
      #1;
      exp = alu_ref(a, b, imm, op);
      checks++;
      if (alu_result !== exp) begin
         failures++;
         $display("FAIL %s a=%h b=%h imm=%0d op=%b got=%h exp=%h", name, a[7:0], b[7:0],
                  imm, op, alu_result, exp);
      end
   endtask

   task automatic check_rd(input logic [7:0] exp, input string name);
      checks++;
      if (mem_rdata !== exp) begin
         failures++;
         $display("FAIL %s addr=%h got=%h exp=%h", name, mem_addr, mem_rdata, exp);
      end
   endtask

   // Drive on falling edge, check old value, clock, check new value.
   task automatic ram_cycle(input logic [7:0] addr, input logic [7:0] wdata,
                            input logic we, input string name);
      @(negedge sysclk);
      mem_addr = addr; mem_wdata = wdata; mem_write = we;
      #1;
      check_rd(ref_mem[addr], {name, "_pre"});
      @(posedge sysclk);
      model_edge();
      #1;
      check_rd(ref_mem[addr], {name, "_post"});
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge sysclk);
      #1;
      mem_addr = 8'h10;
      #1;
      check_rd(8'h00, "reset_rdata");
      @(negedge sysclk);
      rst_n = 1'b1;
   endtask

   task automatic test_rom();
      check_rom(2, "rom_addr2");
      checks++;
      if (opcode !== 3'b100 || rs !== 1'b1 || rt !== 1'b1 || aux !== 3'b101) begin
         failures++;
         $display("FAIL rom_fields2 got=%b_%b_%b_%b exp=100_1_1_101", opcode, rs, rt, aux);
      end
      check_rom(5, "rom_addr5");
      check_rom(200, "rom_addr200");
      for (int i = 0; i < 10; i++) check_rom(i, "rom_low");
      for (int i = 0; i < 20; i++) check_rom($urandom_range(0, 255), "rom_rand");
   endtask

   task automatic test_alu();
      check_alu(8'hF0, 8'h25, 0, 1'b0, "alu_add_wrap");
      check_alu(3, 4, 0, 1'b0, "alu_add_small");
      check_alu(8'h81, 8'h00, 1, 1'b1, "alu_shl_81_1");
      check_alu(8'h01, 8'h00, 7, 1'b1, "alu_shl_01_7");
      check_alu(8'h5A, 8'h33, 0, 1'b1, "alu_shl_imm0");
      check_alu(8'h5A, 8'hFF, 3, 1'b1, "alu_shl_b_ff");
      check_alu(8'h5A, 8'h00, 3, 1'b1, "alu_shl_b_00");
      for (int i = 0; i < 60; i++)
         check_alu($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), "alu_rand");
   endtask

   task automatic test_ram_write_read();
      ram_cycle(8'h10, 8'hA5, 1'b1, "ram_wr_a5");
      @(negedge sysclk);
      mem_write = 1'b0; mem_addr = 8'h11;
      #1;
      check_rd(8'h00, "ram_neighbor");
      mem_addr = 8'h10;
      #1;
      check_rd(8'hA5, "ram_async_follow");
   endtask

   task automatic test_back_to_back();
      ram_cycle(8'h10, 8'h3C, 1'b0, "ram_wr_disabled");
      ram_cycle(8'h10, 8'h3C, 1'b1, "ram_same_cycle");
      for (int i = 0; i < 150; i++)
         ram_cycle(8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), "ram_rand");
   endtask

   task automatic test_async_reset();
      @(negedge sysclk);
      mem_write = 1'b0; mem_addr = 8'h10;
      #2;
      check_rd(ref_mem[8'h10], "ram_before_reset");
      rst_n = 1'b0;
      model_clear();
      #1;
      check_rd(8'h00, "ram_async_clear");
      mem_write = 1'b1; mem_wdata = 8'h77;
      @(posedge sysclk);
      model_edge();
      #1;
      check_rd(8'h00, "ram_reset_blocks_write");
      for (int i = 0; i < 16; i++) begin
         mem_addr = i[7:0];
         #1;
         check_rd(8'h00, "ram_cleared_range");
      end
      @(negedge sysclk);
      mem_write = 1'b0;
      rst_n = 1'b1;
      ram_cycle(8'h10, 8'h5E, 1'b1, "ram_write_after_reset");
      ram_cycle(8'h10, 8'h00, 1'b0, "ram_hold_after_reset");
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rom_table = '{8'h0B, 8'h52, 8'h9D, 8'h64, 8'h27, 8'hE1, 8'h18, 8'hB6};
      instr_addr = 8'h00;
      alu_a = 8'h00; alu_b = 8'h00; alu_imm = 3'd0; alu_op = 1'b0;
      mem_addr = 8'h00; mem_wdata = 8'h00; mem_write = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_rom();
      test_alu();
      test_ram_write_read();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
